// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, transmitter and status signals shared by uart_tx_arbiter and its users
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [2:0]           baud_cfg;
  logic [7:0]           tx_data_byte;
  logic                 tx_send_en;
  logic [2:0]           tx_baud_set;
  logic                 tx_done;
  logic                 busy;
  logic [2:0]           grant_idx;
  logic                 timeout_err;
  modport master (
    output req, req_data, baud_cfg, tx_done,
    input  req_ack, tx_data_byte, tx_send_en, tx_baud_set, busy, grant_idx, timeout_err
  );
  modport slave (
    input  req, req_data, baud_cfg, tx_done,
    output req_ack, tx_data_byte, tx_send_en, tx_baud_set, busy, grant_idx, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter among NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to abort a frame whose tx_done does not arrive within TIMEOUT_CYC WAIT cycles.
module uart_tx_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd200000
) (
  input logic         Clk,
  input logic         Rst,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  localparam logic [NUM_REQ-1:0] ONE = 1;
  state_t state_q, state_d;
  logic [2:0] last_q, last_d, grant_q, grant_d, baud_q, baud_d, sel, idx;
  logic [7:0] data_q, data_d, sel_data;
  logic [NUM_REQ-1:0] ack_q, ack_d, req_sh;
  logic [8*NUM_REQ-1:0] data_sh;
  logic send_q, send_d, busy_q, busy_d, hit, done, expire;
  // Scan downward so the last hit kept is the nearest one above last_q.
  always_comb begin
    sel = '0;
    sel_data = '0;
    hit = 1'b0;
    idx = '0;
    req_sh = '0;
    data_sh = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = 3'((int'(last_q) + i) % NUM_REQ);
      req_sh = bus.req >> idx;
      data_sh = bus.req_data >> {idx, 3'b000};
      if (req_sh[0]) begin
        sel = idx;
        sel_data = data_sh[7:0];
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    grant_d = grant_q;
    data_d = data_q;
    baud_d = baud_q;
    done = state_q == WAIT && (bus.tx_done || expire);
    if (state_q == IDLE) begin
      baud_d = bus.baud_cfg;
      if (hit) begin
        state_d = START;
        grant_d = sel;
        data_d = sel_data;
      end
    end
    if (state_q == START) state_d = WAIT;
    if (done) begin
      state_d = IDLE;
      last_d = grant_q;
    end
    send_d = state_q == START;
    busy_d = state_d != IDLE;
    ack_d = done ? ONE << grant_q : '0;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state_q <= IDLE;
      last_q <= 3'(NUM_REQ - 1);
      grant_q <= '0;
      data_q <= '0;
      baud_q <= '0;
      send_q <= 1'b0;
      busy_q <= 1'b0;
      ack_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      grant_q <= grant_d;
      data_q <= data_d;
      baud_q <= baud_d;
      send_q <= send_d;
      busy_q <= busy_d;
      ack_q <= ack_d;
    end
`ifdef ARB_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // A tx_done landing on the expiry cycle wins, so no error is flagged then.
  assign cnt_d = state_q == WAIT ? cnt_q + 24'd1 : '0;
  assign expire = cnt_d == TIMEOUT_CYC;
  assign err_d = state_q == WAIT && expire && !bus.tx_done;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign bus.timeout_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign expire = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  assign bus.req_ack = ack_q;
  assign bus.tx_data_byte = data_q;
  assign bus.tx_send_en = send_q;
  assign bus.tx_baud_set = baud_q;
  assign bus.busy = busy_q;
  assign bus.grant_idx = grant_q;
endmodule
